// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end feeding decode from a prefetch FIFO of {pc, instr} pairs.
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   imem_req_o/addr_o    fetch request and address, held until imem_gnt_i
//   imem_gnt_i           request accepted this cycle
//   imem_rvalid_i/rdata_i one response per grant, at least one cycle later
//   redirect_i/pc_i      flush the FIFO and restart fetch at redirect_pc_i
//   if_valid_o/pc_o/instr_o  FIFO head toward decode (zero when empty)
//   id_ready_i           decode takes the head this cycle
//   q_count_o            occupied FIFO entries
module fetch_queue #(
   parameter int PC_W  = 9,
   parameter int INS_W = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   output logic                       imem_req_o,
   output logic [PC_W-1:0]            imem_addr_o,
   input  logic                       imem_gnt_i,
   input  logic                       imem_rvalid_i,
   input  logic [INS_W-1:0]           imem_rdata_i,
   input  logic                       redirect_i,
   input  logic [PC_W-1:0]            redirect_pc_i,
   output logic                       if_valid_o,
   output logic [PC_W-1:0]            if_pc_o,
   output logic [INS_W-1:0]           if_instr_o,
   input  logic                       id_ready_i,
   output logic [$clog2(DEPTH):0]     q_count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
   state_t            state_q, state_d;
   logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]     count_q;
   logic [PC_W-1:0]   pc_mem_q  [DEPTH];
   logic [INS_W-1:0]  ins_mem_q [DEPTH];
   logic              push, pop;
   // IDLE only requests when a slot is free; pops can only add room before the
   // response lands, so the outstanding request always has a reserved slot.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      push       = 1'b0;
      case (state_q)
         IDLE: state_d = (count_q < CW'(DEPTH)) ? REQ : IDLE;
         REQ:  state_d = imem_gnt_i ? WAIT : REQ;
         WAIT: begin
            push       = imem_rvalid_i;
            fetch_pc_d = imem_rvalid_i ? fetch_pc_q + PC_W'(4) : fetch_pc_q;
            state_d    = imem_rvalid_i ? IDLE : WAIT;
         end
         DROP: state_d = imem_rvalid_i ? IDLE : DROP;
         default: state_d = IDLE;
      endcase
      // Redirect wins: go to DROP only if a response is still owed after this edge.
      // A response arriving in DROP on the redirect edge settles the debt, so go idle.
      if (redirect_i) begin
         push       = 1'b0;
         fetch_pc_d = redirect_pc_i;
         state_d    = ((state_q == REQ && imem_gnt_i) ||
                       ((state_q == WAIT || state_q == DROP) && !imem_rvalid_i)) ? DROP : IDLE;
      end
   end
   assign pop         = if_valid_o & id_ready_i & ~redirect_i;
   assign imem_req_o  = (state_q == REQ);
   assign imem_addr_o = fetch_pc_q;
   assign if_valid_o  = (count_q != '0);
   assign if_pc_o     = if_valid_o ? pc_mem_q[rd_ptr_q] : '0;
   assign if_instr_o  = if_valid_o ? ins_mem_q[rd_ptr_q] : '0;
   assign q_count_o   = count_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         fetch_pc_q <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= redirect_i ? '0 : rd_ptr_q + AW'(pop);
         wr_ptr_q   <= redirect_i ? '0 : wr_ptr_q + AW'(push);
         count_q    <= redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
      end
   end
   // Storage needs no reset: contents are only visible when count_q says so.
   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
         ins_mem_q[wr_ptr_q] <= imem_rdata_i;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a simple grant/response memory model.
module tb_fetch_queue;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, gnt, rvalid, redirect, valid, id_ready;
   logic [8:0]  addr, redirect_pc, pc;
   logic [31:0] rdata, instr;
   logic [2:0]  count;
   logic        gnt_en, bad;
   logic        pend;
   int          lat, cnt;
   int          checks = 0;
   int          failures = 0;
   fetch_queue dut (
      .clk_i(clk), .rst_ni(rst_n),
      .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
      .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .if_valid_o(valid), .if_pc_o(pc), .if_instr_o(instr),
      .id_ready_i(id_ready), .q_count_o(count)
   );
   always #5 clk = ~clk;
   assign gnt    = req & gnt_en;
   assign rvalid = pend && cnt == 0;
   assign rdata  = bad ? 32'hDEADBEEF : 32'h0000_0013;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= 1'b0;
         cnt  <= 0;
      end else if (gnt) begin
         pend <= 1'b1;
         cnt  <= lat - 1;
      end else if (pend) begin
         if (cnt == 0) pend <= 1'b0;
         else cnt <= cnt - 1;
      end
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_valid(input string tag);
      for (int k = 0; k < 20 && !valid; k++) step();
      chk(tag, 64'(valid), 64'd1);
   endtask
   task automatic wait_req(input string tag);
      for (int k = 0; k < 20 && !req; k++) step();
      chk(tag, 64'(req), 64'd1);
   endtask
   initial begin
      rst_n = 1'b0; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
      gnt_en = 1'b1; bad = 1'b0; lat = 1;
      #1;
      chk("rst_req", 64'(req), 64'd0);
      chk("rst_addr", 64'(addr), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_pc", 64'(pc), 64'd0);
      chk("rst_instr", 64'(instr), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      // 1: latency and sequential pcs
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("t1_valid_c1", 64'(valid), 64'd0);
      chk("t1_req_c1", 64'(req), 64'd1);
      chk("t1_addr_c1", 64'(addr), 64'd0);
      step();
      chk("t1_valid_c2", 64'(valid), 64'd0);
      step();
      chk("t1_valid_c3", 64'(valid), 64'd1);
      chk("t1_pc0", 64'(pc), 64'd0);
      chk("t1_instr0", 64'(instr), 64'h13);
      for (int i = 1; i < 4; i++) begin
         step();
         wait_valid("t1_wait");
         chk("t1_pc", 64'(pc), 64'(4 * i));
         chk("t1_instr", 64'(instr), 64'h13);
      end
      // 2: saturation with decode stalled, then ordered drain
      rst_n = 1'b0;
      step();
      id_ready = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (30) step();
      chk("t2_count_full", 64'(count), 64'd4);
      chk("t2_req_full", 64'(req), 64'd0);
      chk("t2_valid_full", 64'(valid), 64'd1);
      id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_drain_pc", 64'(pc), 64'(4 * i));
         step();
      end
      chk("t2_pc16", 64'(pc), 64'd16);
      chk("t2_count_pushpop", 64'(count), 64'd1);
      // 3: redirect while waiting; the late response is dropped
      lat = 2;
      step();
      wait_req("t3_req");
      step();
      redirect = 1'b1; redirect_pc = 9'h040; bad = 1'b1;
      step();
      redirect = 1'b0;
      chk("t3_rvalid_now", 64'(rvalid), 64'd1);
      chk("t3_valid_after", 64'(valid), 64'd0);
      chk("t3_instr_after", 64'(instr), 64'd0);
      step();
      bad = 1'b0; lat = 1;
      chk("t3_req_idle", 64'(req), 64'd0);
      chk("t3_valid_idle", 64'(valid), 64'd0);
      step();
      chk("t3_req", 64'(req), 64'd1);
      chk("t3_addr", 64'(addr), 64'h040);
      wait_valid("t3_wait");
      chk("t3_pc", 64'(pc), 64'h040);
      chk("t3_instr", 64'(instr), 64'h13);
      // 4: redirect and pop together with three entries queued
      id_ready = 1'b0;
      for (int k = 0; k < 40 && count != 3'd3; k++) step();
      chk("t4_count3", 64'(count), 64'd3);
      id_ready = 1'b1; redirect = 1'b1; redirect_pc = 9'h080;
      step();
      redirect = 1'b0;
      chk("t4_count", 64'(count), 64'd0);
      chk("t4_valid", 64'(valid), 64'd0);
      chk("t4_pc_empty", 64'(pc), 64'd0);
      chk("t4_req_next", 64'(req), 64'd0);
      step();
      chk("t4_req", 64'(req), 64'd1);
      chk("t4_addr", 64'(addr), 64'h080);
      wait_valid("t4_wait");
      chk("t4_pc", 64'(pc), 64'h080);
      // 5: fetch address wraps
      redirect = 1'b1; redirect_pc = 9'h1FC;
      step();
      redirect = 1'b0;
      wait_valid("t5_wait_a");
      chk("t5_pc_1fc", 64'(pc), 64'h1FC);
      step();
      wait_valid("t5_wait_b");
      chk("t5_pc_wrap", 64'(pc), 64'd0);
      // 6: asynchronous reset while a request is pending
      gnt_en = 1'b0;
      wait_req("t6_req");
      step();
      step();
      chk("t6_req_held", 64'(req), 64'd1);
      chk("t6_addr_held", 64'(addr), 64'd4);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_req_async", 64'(req), 64'd0);
      chk("t6_addr_async", 64'(addr), 64'd0);
      chk("t6_count_async", 64'(count), 64'd0);
      chk("t6_valid_async", 64'(valid), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      gnt_en = 1'b1;
      step();
      chk("t6_req_restart", 64'(req), 64'd1);
      chk("t6_addr_restart", 64'(addr), 64'd0);
      wait_valid("t6_wait");
      chk("t6_pc", 64'(pc), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
